out_signature_misr: RTL and testbench
=====================================

# out_signature_misr

Downstream consumer of the DUT's flattened output bus in the fuzz harness. Each sampled `out_flat` word is compressed into a 32-bit multiple-input signature. Samples are counted, and the block reports completion after a programmed number of samples. The resulting signature and count give a single compact value to compare across simulators, instead of diffing per-cycle `OUT=` traces.

## Interface
Parameters:
- `W`, 330, width of the consumed output bus.
- `SEED`, 32'h0000_0000, signature value loaded on reset and on every `start`.
- `POLY`, 32'h04C1_1DB7, Galois feedback polynomial.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `start`, input, 1, single-cycle pulse that begins a capture run.
- `num_cycles`, input, 32, number of samples to fold; latched on `start`.
- `data_in`, input, W, DUT output word (`out_flat`).
- `data_valid`, input, 1, qualifies `data_in` this cycle.
- `sig_out`, output, 32, current signature.
- `cycle_cnt`, output, 32, samples folded in the current run.
- `busy`, output, 1, high in RUN.
- `done`, output, 1, high in DONE.

## Operation
- **Fold:**
  - Zero-extend `data_in` to N=ceil(W/32)*32 bits, which is 352 for the default W.
  - XOR all N/32 32-bit chunks into F. Chunk 0 is bits [31:0], the top chunk holds the padding.
- **Signature step:** sig_next = ({sig[30:0],1'b0} ^ (sig[31] ? POLY : 0)) ^ F. Arithmetic is modulo 2^32 with no carries.
- **States:** IDLE, RUN, DONE. The state encoding is internal.
- **IDLE:**
  - `start`=1 with `num_cycles`≠0 → RUN.
  - `start`=1 with `num_cycles`=0 → DONE.
  - In both cases, sig←SEED, cnt←0 and the limit is latched.
- **RUN:**
  - Each cycle with `data_valid`=1 applies one signature step and cnt←cnt+1.
  - When the increment makes cnt equal the latched limit → DONE.
  - `data_valid`=0 leaves sig and cnt unchanged.
- **DONE:**
  - sig and cnt are frozen and `data_valid` is ignored.
  - `start` behaves as in IDLE.
- **`start` while in RUN:** restarts the run (sig←SEED, cnt←0, new limit latched). The `data_valid` sample in that same cycle is discarded.
- **Counter bound:** cnt never exceeds the latched limit and does not wrap. A limit of 32'hFFFF_FFFF is legal.
- **Width rule:** the fold must handle any W≥1, including a W that is not a multiple of 32, via generate-time chunking.

## Timing
- **Reset values while `rst_n`=0:**
  - state=IDLE, `sig_out`=SEED, `cycle_cnt`=0, `busy`=0, `done`=0.
  - Reset takes effect immediately, not on a clock edge. This includes assertion mid-RUN.
- **Latency:**
  - A valid sample at edge k is reflected in `sig_out` and `cycle_cnt` after edge k.
  - `done` rises after the same edge that folds the final sample.
- **start:**
  - `busy` rises one cycle after the `start` edge.
  - `busy` and `done` are never high together.
  - The limit is sampled only in the `start` cycle; later changes to `num_cycles` have no effect on the run.
- **Outputs:** all outputs are registered with no combinational input-to-output path.
- **Input setup:** inputs are driven on the negedge by the harness. No input synchronisation is required.

## Test plan
- **Reset values:** hold `rst_n`=0, then release → `sig_out`=0, `cycle_cnt`=0, `busy`=0, `done`=0. Assert `rst_n` mid-RUN → the same values immediately, without waiting for a clock edge.
- **Single sample:** `start` with `num_cycles`=1, then one valid sample with `data_in`[31:0]=32'h8000_0000 and all other bits 0 → `sig_out`=32'h8000_0000, `cycle_cnt`=1, `done`=1 on the next cycle.
- **Feedback tap:** `num_cycles`=2; sample 1 = 32'h8000_0000, sample 2 = all zeros → `sig_out`=32'h04C1_1DB7, `done`=1 after the second sample.
- **Chunk fold:** `data_in` with chunk0=32'h1234_5678, chunk10 (bits [329:320] = 10'h3FF)=32'h0000_03FF, all else 0, `num_cycles`=1 → `sig_out`=32'h1234_5587.
- **Gaps and freeze:**
  - `num_cycles`=3 with `data_valid` pattern 1,0,0,1,1 → `cycle_cnt` steps 1,1,1,2,3.
  - `done` asserts after the 5th edge.
  - Further valid samples leave `sig_out` unchanged.
- **Zero limit and restart:**
  - `start` with `num_cycles`=0 → `done`=1 next cycle with `sig_out`=SEED.
  - `start` during RUN with concurrent `data_valid` → `cycle_cnt`=0 and `sig_out`=SEED next cycle; the sample is not folded.

Source files
------------

// File: rtl/out_signature_misr.sv
// Output-bus signature compressor: folds each sampled word into a
// 32-bit Galois MISR and counts samples up to a latched limit.
module out_signature_misr #(
  parameter int          W    = 330,
  parameter logic [31:0] SEED = 32'h0000_0000,
  parameter logic [31:0] POLY = 32'h04C1_1DB7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   num_cycles,
  input  logic [W-1:0]  data_in,
  input  logic          data_valid,
  output logic [31:0]   sig_out,
  output logic [31:0]   cycle_cnt,
  output logic          busy,
  output logic          done
);

  localparam int NC = (W + 31) / 32;
  localparam int N  = NC * 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sig_q, sig_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] lim_q, lim_d;
  logic [N-1:0] data_ext;
  logic [31:0] fold;
  logic [31:0] sig_step;
  logic [31:0] cnt_inc;

  always_comb begin
    data_ext = '0;
    data_ext[W-1:0] = data_in;
  end

  always_comb begin
    fold = '0;
    for (int i = 0; i < NC; i++) begin
      fold = fold ^ data_ext[i*32 +: 32];
    end
  end

  assign sig_step = {sig_q[30:0], 1'b0}
                  ^ (sig_q[31] ? POLY : 32'h0)
                  ^ fold;
  assign cnt_inc  = cnt_q + 32'd1;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    if (start) begin
      // start wins over any concurrent sample, in every state
      sig_d   = SEED;
      cnt_d   = '0;
      lim_d   = num_cycles;
      state_d = (num_cycles != 32'd0) ? S_RUN : S_DONE;
    end else begin
      case (state_q)
        S_RUN: begin
          if (data_valid) begin
            sig_d = sig_step;
            cnt_d = cnt_inc;
            if (cnt_inc == lim_q) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  assign sig_out   = sig_q;
  assign cycle_cnt = cnt_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_out_signature_misr.sv
// Directed, table-driven bench for out_signature_misr.
// Inputs change on negedge; outputs sampled 1ns after posedge.
module tb_out_signature_misr;

  localparam int W = 330;

  typedef struct {
    logic         st;
    logic [31:0]  nc;
    logic         dv;
    logic [W-1:0] data;
    logic [31:0]  esig;
    logic [31:0]  ecnt;
    logic         ebusy;
    logic         edone;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [31:0]   num_cycles;
  logic [W-1:0]  data_in;
  logic          data_valid;
  logic [31:0]   sig_out;
  logic [31:0]   cycle_cnt;
  logic          busy;
  logic          done;

  int total;
  int passed;
  vec_t vq[$];

  out_signature_misr #(
    .W(W),
    .SEED(32'h0000_0000),
    .POLY(32'h04C1_1DB7)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_cycles(num_cycles),
    .data_in(data_in),
    .data_valid(data_valid),
    .sig_out(sig_out),
    .cycle_cnt(cycle_cnt),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] esig,
                         input logic [31:0] ecnt,
                         input logic eb,
                         input logic ed);
    chk({tag, ".sig"}, sig_out, esig);
    chk({tag, ".cnt"}, cycle_cnt, ecnt);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
  endtask

  task automatic add(input logic st, input logic [31:0] nc,
                     input logic dv, input logic [W-1:0] d,
                     input logic [31:0] es, input logic [31:0] ec,
                     input logic eb, input logic ed);
    vec_t v;
    v.st = st; v.nc = nc; v.dv = dv; v.data = d;
    v.esig = es; v.ecnt = ec; v.ebusy = eb; v.edone = ed;
    vq.push_back(v);
  endtask

  initial begin
    logic [W-1:0] cf;
    total = 0;
    passed = 0;
    start = 0;
    num_cycles = 0;
    data_in = '0;
    data_valid = 0;
    rst_n = 0;

    cf = '0;
    cf[31:0] = 32'h1234_5678;
    cf[329:320] = 10'h3FF;

    // single sample
    add(1, 1, 0, '0,           32'h0,          0, 1, 0);
    add(0, 0, 1, 32'h8000_0000, 32'h8000_0000, 1, 0, 1);
    // feedback tap
    add(1, 2, 0, '0,           32'h0,          0, 1, 0);
    add(0, 0, 1, 32'h8000_0000, 32'h8000_0000, 1, 1, 0);
    add(0, 0, 1, '0,           32'h04C1_1DB7,  2, 0, 1);
    // chunk fold incl. partial top chunk
    add(1, 1, 0, '0,           32'h0,          0, 1, 0);
    add(0, 0, 1, cf,           32'h1234_5587,  1, 0, 1);
    // gaps then freeze
    add(1, 3, 0, '0,           32'h0,          0, 1, 0);
    add(0, 0, 1, 32'h1,        32'h1,          1, 1, 0);
    add(0, 0, 0, 32'hF,        32'h1,          1, 1, 0);
    add(0, 0, 0, 32'hF,        32'h1,          1, 1, 0);
    add(0, 0, 1, 32'h1,        32'h3,          2, 1, 0);
    add(0, 0, 1, 32'h3,        32'h5,          3, 0, 1);
    add(0, 0, 1, 32'hFFFF,     32'h5,          3, 0, 1);
    add(0, 0, 1, 32'h7,        32'h5,          3, 0, 1);
    // zero limit
    add(1, 0, 1, 32'h5,        32'h0,          0, 0, 1);
    add(0, 0, 1, 32'h9,        32'h0,          0, 0, 1);
    // restart during run, sample discarded
    add(1, 5, 0, '0,           32'h0,          0, 1, 0);
    add(0, 0, 1, 32'h8000_0000, 32'h8000_0000, 1, 1, 0);
    add(1, 2, 1, 32'h1234,     32'h0,          0, 1, 0);
    // num_cycles change mid-run has no effect
    add(0, 1, 1, 32'h8000_0000, 32'h8000_0000, 1, 1, 0);
    add(0, 1, 1, 32'h8000_0000, 32'h84C1_1DB7, 2, 0, 1);
    // maximum limit
    add(1, 32'hFFFF_FFFF, 0, '0, 32'h0,        0, 1, 0);
    add(0, 0, 1, 32'h1,        32'h1,          1, 1, 0);

    repeat (3) @(negedge clk);
    #1 chk_all("rst_hold", 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1 chk_all("rst_rel", 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      start = vq[i].st;
      num_cycles = vq[i].nc;
      data_valid = vq[i].dv;
      data_in = vq[i].data;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), vq[i].esig,
                 vq[i].ecnt, vq[i].ebusy, vq[i].edone);
    end

    // async reset mid-run, checked between edges
    @(negedge clk);
    start = 0;
    data_valid = 0;
    #2 rst_n = 0;
    #1 chk_all("rst_async", 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    data_valid = 1;
    data_in = 32'h1;
    @(posedge clk);
    #1 chk_all("post_rst_idle", 32'h0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
